// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: baud defaults, FSM state encodings and frame geometry.
// The receive path imports the same package.
package uart_tx_pkg;

    localparam int unsigned BAUD_DIV_DEFAULT = 2603;
    localparam int unsigned CNT_W            = 13;
    localparam int unsigned DEPTH_DEFAULT    = 8;
    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned FRAME_BITS       = 10;

    typedef logic [DATA_BITS-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte write port and line/status outputs of the UART transmitter.
interface uart_tx_if;
    import uart_tx_pkg::*;

    byte_t data_in;
    logic  WR;
    logic  TX;
    logic  busy;
    logic  full;
    logic  empty;

    modport master (
        output data_in, WR,
        input  TX, busy, full, empty
    );

    modport slave (
        input  data_in, WR,
        output TX, busy, full, empty
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter; flags derive from the registered count.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic  Clk,
    input  logic  Reset,
    input  byte_t data_in,
    input  logic  WR,
    input  logic  RD,
    output byte_t data_out,
    output logic  full,
    output logic  empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    byte_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             do_wr_c,  do_rd_c;

    // Writes are gated by the pre-pop full flag; pops by the registered empty flag.
    always_comb begin
        do_wr_c  = WR && !full_q;
        do_rd_c  = RD && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_wr_c, do_rd_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge Clk) begin
        if (do_wr_c) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: byte FIFO, baud counter, shift register and frame FSM.
// TX and busy are registered from the current state, so the line lags the FSM by one cycle.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
    input  logic     Clk,
    input  logic     Reset,
    uart_tx_if.slave bus
);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_e        state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    byte_t            shift_q,   shift_d;
    logic             tx_q,      tx_d;
    logic             busy_q,    busy_d;
    logic             baud_done_c;
    logic             fifo_rd_c;
    byte_t            fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .data_in  (bus.data_in),
        .WR       (bus.WR),
        .RD       (fifo_rd_c),
        .data_out (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Next-state, counter and shift logic; counter is held at zero while idle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        fifo_rd_c   = 1'b0;
        baud_done_c = (cnt_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_rd_c = 1'b1;
                    shift_d   = fifo_dout;
                    state_d   = START;
                end
            end
            START: begin
                if (baud_done_c) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_done_c) begin
                    cnt_d     = '0;
                    shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'(1);
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_done_c) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.TX    = tx_q;
    assign bus.busy  = busy_q;
    assign bus.full  = fifo_full;
    assign bus.empty = fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with BAUD_DIV=4, DEPTH=4 and a line-side 8N1 decoder.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int unsigned BAUD  = 4;
    localparam int unsigned DEP   = 4;
    localparam int unsigned FRAME = FRAME_BITS * BAUD;

    logic Clk;
    logic Reset;
    int   cyc;
    int   n_checks;
    int   n_errors;

    logic [7:0] rx_q[$];
    int         rx_start[$];
    int         rx_bad;

    uart_tx_if bus ();

    uart_tx #(
        .BAUD_DIV (BAUD),
        .DEPTH    (DEP)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Line decoder: samples each bit at its middle, logs bytes and start-bit cycles.
    initial begin
        logic [7:0] d;
        logic       s0;
        logic       s1;
        int         t0;
        rx_bad = 0;
        forever begin
            @(negedge Clk);
            if (bus.TX === 1'b0 && Reset === 1'b0) begin
                t0 = cyc;
                repeat (BAUD / 2) @(negedge Clk);
                s0 = bus.TX;
                for (int k = 0; k < 8; k++) begin
                    repeat (BAUD) @(negedge Clk);
                    d[k] = bus.TX;
                end
                repeat (BAUD) @(negedge Clk);
                s1 = bus.TX;
                if (s0 === 1'b0 && s1 === 1'b1) begin
                    rx_q.push_back(d);
                    rx_start.push_back(t0);
                end else begin
                    rx_bad++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic wr_byte(input logic [7:0] b);
        bus.data_in = b;
        bus.WR      = 1'b1;
        @(negedge Clk);
        bus.WR      = 1'b0;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_start.delete();
        rx_bad = 0;
    endtask

    task automatic test_reset();
        int lows;
        Reset       = 1'b1;
        bus.WR      = 1'b0;
        bus.data_in = 8'h00;
        repeat (2) @(negedge Clk);
        n_checks++; if (bus.TX !== 1'b1) begin n_errors++; $display("FAIL reset_tx: got %b want 1", bus.TX); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
        Reset = 1'b0;
        lows  = 0;
        repeat (50) begin
            @(negedge Clk);
            if (bus.TX !== 1'b1) lows++;
        end
        n_checks++; if (lows !== 0) begin n_errors++; $display("FAIL reset_idle_line: %0d non-high cycles, want 0", lows); end
        n_checks++; if (rx_q.size() !== 0) begin n_errors++; $display("FAIL reset_no_frames: got %0d frames want 0", rx_q.size()); end
    endtask

    task automatic test_single();
        logic       tx_s [45];
        logic       bz_s [45];
        logic [9:0] exp_f;
        int         busy_cnt;
        logic [7:0] got;
        clear_rx();
        exp_f = {1'b1, 8'hA5, 1'b0};
        wr_byte(8'hA5);
        n_checks++; if (bus.empty !== 1'b0) begin n_errors++; $display("FAIL single_empty_after_wr: got %b want 0", bus.empty); end
        n_checks++; if (bus.TX !== 1'b1) begin n_errors++; $display("FAIL single_tx_edge_n: got %b want 1", bus.TX); end
        @(negedge Clk);
        n_checks++; if (bus.TX !== 1'b1) begin n_errors++; $display("FAIL single_tx_edge_n1: got %b want 1", bus.TX); end
        n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL single_empty_after_pop: got %b want 1", bus.empty); end
        for (int i = 0; i < 45; i++) begin
            @(negedge Clk);
            tx_s[i] = bus.TX;
            bz_s[i] = bus.busy;
        end
        n_checks++; if (tx_s[0] !== 1'b0) begin n_errors++; $display("FAIL single_start_latency: got %b want 0", tx_s[0]); end
        n_checks++; if (tx_s[3] !== 1'b0 || tx_s[4] !== 1'b1) begin n_errors++; $display("FAIL single_start_width: got %b%b want 01", tx_s[3], tx_s[4]); end
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (tx_s[2 + 4 * k] !== exp_f[k]) begin
                n_errors++; $display("FAIL single_bit%0d: got %b want %b", k, tx_s[2 + 4 * k], exp_f[k]);
            end
        end
        busy_cnt = 0;
        for (int i = 0; i < 45; i++) if (bz_s[i] === 1'b1) busy_cnt++;
        n_checks++; if (busy_cnt !== 40) begin n_errors++; $display("FAIL single_busy_len: got %0d want 40", busy_cnt); end
        n_checks++; if (bz_s[0] !== 1'b1 || bz_s[40] !== 1'b0) begin n_errors++; $display("FAIL single_busy_window: got %b..%b want 1..0", bz_s[0], bz_s[40]); end
        got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        n_checks++; if (rx_q.size() !== 1 || got !== 8'hA5) begin n_errors++; $display("FAIL single_rx: got %0d frames first %h want 1 frame a5", rx_q.size(), got); end
    endtask

    task automatic test_back_to_back();
        int         busy_hi;
        int         rises;
        logic       prev;
        logic [7:0] got0;
        logic [7:0] got1;
        int         gap;
        clear_rx();
        bus.data_in = 8'h00;
        bus.WR      = 1'b1;
        @(negedge Clk);
        bus.data_in = 8'hFF;
        @(negedge Clk);
        bus.WR = 1'b0;
        busy_hi = 0;
        rises   = 0;
        prev    = bus.busy;
        repeat (100) begin
            @(negedge Clk);
            if (bus.busy === 1'b1) busy_hi++;
            if (prev === 1'b0 && bus.busy === 1'b1) rises++;
            prev = bus.busy;
        end
        got0 = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        got1 = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
        gap  = (rx_start.size() > 1) ? rx_start[1] - rx_start[0] : -1;
        n_checks++; if (rx_q.size() !== 2) begin n_errors++; $display("FAIL b2b_count: got %0d frames want 2", rx_q.size()); end
        n_checks++; if (got0 !== 8'h00) begin n_errors++; $display("FAIL b2b_byte0: got %h want 00", got0); end
        n_checks++; if (got1 !== 8'hFF) begin n_errors++; $display("FAIL b2b_byte1: got %h want ff", got1); end
        n_checks++; if (gap !== int'(FRAME) + 1) begin n_errors++; $display("FAIL b2b_start_spacing: got %0d want %0d", gap, FRAME + 1); end
        n_checks++; if (busy_hi !== 80 || rises !== 2) begin n_errors++; $display("FAIL b2b_busy: got %0d high/%0d rises want 80/2", busy_hi, rises); end
        n_checks++; if (rx_bad !== 0) begin n_errors++; $display("FAIL b2b_framing: got %0d bad frames want 0", rx_bad); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp_b [5];
        logic [7:0] got;
        int         waited;
        clear_rx();
        exp_b = '{8'hEE, 8'h01, 8'h02, 8'h03, 8'h04};
        wr_byte(8'hEE);
        waited = 0;
        while (bus.busy !== 1'b1 && waited < 10) begin @(negedge Clk); waited++; end
        n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL full_busy_wait: got %b want 1", bus.busy); end
        for (int i = 1; i <= 5; i++) begin
            bus.data_in = 8'(i);
            bus.WR      = 1'b1;
            @(negedge Clk);
            n_checks++;
            if (bus.full !== (i >= 4)) begin
                n_errors++; $display("FAIL full_flag_after_wr%0d: got %b want %b", i, bus.full, (i >= 4));
            end
        end
        bus.WR = 1'b0;
        waited = 0;
        while (rx_q.size() < 5 && waited < 400) begin @(negedge Clk); waited++; end
        repeat (60) @(negedge Clk);
        n_checks++; if (rx_q.size() !== 5) begin n_errors++; $display("FAIL full_frame_count: got %0d want 5", rx_q.size()); end
        for (int k = 0; k < 5; k++) begin
            got = (rx_q.size() > k) ? rx_q[k] : 8'hxx;
            n_checks++;
            if (got !== exp_b[k]) begin n_errors++; $display("FAIL full_byte%0d: got %h want %h", k, got, exp_b[k]); end
        end
        n_checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_errors++; $display("FAIL full_drained: got empty=%b full=%b want 1/0", bus.empty, bus.full); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_b [3];
        logic [7:0] got;
        int         waited;
        int         gap;
        clear_rx();
        exp_b = '{8'h11, 8'h22, 8'h33};
        wr_byte(8'h11);
        wr_byte(8'h22);
        repeat (40) @(negedge Clk);
        n_checks++; if (bus.empty !== 1'b0 || bus.busy !== 1'b1) begin n_errors++; $display("FAIL simul_pre: got empty=%b busy=%b want 0/1", bus.empty, bus.busy); end
        wr_byte(8'h33);
        n_checks++; if (bus.empty !== 1'b0 || bus.full !== 1'b0) begin n_errors++; $display("FAIL simul_count: got empty=%b full=%b want 0/0", bus.empty, bus.full); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL simul_idle_cycle: got busy=%b want 0", bus.busy); end
        @(negedge Clk);
        n_checks++; if (bus.TX !== 1'b0 || bus.empty !== 1'b0) begin n_errors++; $display("FAIL simul_next_start: got tx=%b empty=%b want 0/0", bus.TX, bus.empty); end
        waited = 0;
        while (rx_q.size() < 3 && waited < 200) begin @(negedge Clk); waited++; end
        repeat (10) @(negedge Clk);
        for (int k = 0; k < 3; k++) begin
            got = (rx_q.size() > k) ? rx_q[k] : 8'hxx;
            n_checks++;
            if (got !== exp_b[k]) begin n_errors++; $display("FAIL simul_byte%0d: got %h want %h", k, got, exp_b[k]); end
        end
        gap = (rx_start.size() > 2) ? rx_start[2] - rx_start[1] : -1;
        n_checks++; if (gap !== int'(FRAME) + 1) begin n_errors++; $display("FAIL simul_spacing: got %0d want %0d", gap, FRAME + 1); end
        n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL simul_drained: got empty=%b want 1", bus.empty); end
    endtask

    task automatic test_reset_mid();
        int lows;
        int busy_hi;
        wr_byte(8'h3C);
        wr_byte(8'h55);
        wr_byte(8'h66);
        n_checks++; if (bus.TX !== 1'b0 || bus.empty !== 1'b0) begin n_errors++; $display("FAIL rmid_setup: got tx=%b empty=%b want 0/0", bus.TX, bus.empty); end
        repeat (17) @(negedge Clk);
        n_checks++; if (bus.TX !== 1'b1 || bus.busy !== 1'b1) begin n_errors++; $display("FAIL rmid_bit3: got tx=%b busy=%b want 1/1", bus.TX, bus.busy); end
        Reset = 1'b1;
        @(negedge Clk);
        n_checks++; if (bus.TX !== 1'b1) begin n_errors++; $display("FAIL rmid_tx: got %b want 1", bus.TX); end
        n_checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_errors++; $display("FAIL rmid_fifo: got empty=%b full=%b want 1/0", bus.empty, bus.full); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
        Reset   = 1'b0;
        lows    = 0;
        busy_hi = 0;
        repeat (120) begin
            @(negedge Clk);
            if (bus.TX !== 1'b1) lows++;
            if (bus.busy !== 1'b0) busy_hi++;
        end
        n_checks++; if (lows !== 0 || busy_hi !== 0) begin n_errors++; $display("FAIL rmid_no_frames: got %0d low/%0d busy cycles want 0/0", lows, busy_hi); end
        n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL rmid_empty_after: got %b want 1", bus.empty); end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        Reset       = 1'b1;
        bus.WR      = 1'b0;
        bus.data_in = 8'h00;
        @(negedge Clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
